// File: rtl/rv_ibus_bridge.sv
// rv_ibus_bridge: fetch-port to OBI-style memory bridge with one outstanding request.
// Define RV_IBUS_ERR_EN to return the bus error with each word on o_f_fault.
module rv_ibus_bridge #(
  parameter int IADDR_SPACE_BITS = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [IADDR_SPACE_BITS-1:0] i_f_addr,
  input  logic                        i_f_cyc,
  input  logic                        i_flush,
  output logic                        o_f_ack,
  output logic [31:0]                 o_f_instruction,
  output logic                        o_f_fault,
  output logic                        o_m_req,
  output logic [31:0]                 o_m_addr,
  input  logic                        i_m_gnt,
  input  logic                        i_m_rvalid,
  input  logic [31:0]                 i_m_rdata,
  input  logic                        i_m_err
);
  localparam int W = IADDR_SPACE_BITS;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DROP} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_addr;
  logic r_flushed, w_same, w_match, w_capture;
  logic w_unused_addr;
  assign w_unused_addr = ^i_f_addr[1:0];
  assign w_same = i_f_addr[W-1:2] == r_addr[W-1:2];
  assign w_match = i_f_cyc && w_same;
  assign o_m_req = r_state == REQ;
  assign o_m_addr = 32'(r_addr);
  always_comb begin
    w_next = r_state;
    o_f_ack = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: w_next = i_f_cyc && !i_flush ? REQ : IDLE;
      REQ:  w_next = !i_m_gnt ? REQ : (r_flushed || i_flush) ? DROP : WAIT;
      WAIT: begin
        w_capture = i_m_rvalid;
        o_f_ack = i_m_rvalid && !i_flush && w_match;
        w_next = i_m_rvalid ? ((i_flush || w_match) ? IDLE : HOLD) : (i_flush ? DROP : WAIT);
      end
      HOLD: begin
        o_f_ack = !i_flush && w_match;
        w_next = (i_flush || !w_same || i_f_cyc) ? IDLE : HOLD;
      end
      DROP: w_next = i_m_rvalid ? IDLE : DROP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_addr <= '0;
      r_flushed <= 1'b0;
      o_f_instruction <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == REQ) begin
        r_addr <= {i_f_addr[W-1:2], 2'b00};
        r_flushed <= 1'b0;
      end else if (r_state == REQ && i_flush) begin
        r_flushed <= 1'b1;
      end
      if (w_capture) o_f_instruction <= i_m_rdata;
    end
  end
`ifdef RV_IBUS_ERR_EN
  logic r_fault;
  always_ff @(posedge i_clk) begin
    if (i_reset) r_fault <= 1'b0;
    else if (w_capture) r_fault <= i_m_err;
  end
  assign o_f_fault = r_fault;
`else
  logic w_unused_err;
  assign w_unused_err = i_m_err;
  assign o_f_fault = 1'b0;
`endif
endmodule

// File: tb/tb_rv_ibus_bridge.sv
// tb_rv_ibus_bridge: randomized transaction scenarios with a scoreboard-driven monitor.
module tb_rv_ibus_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] f_addr;
  logic        f_cyc, flush, f_ack, f_fault, m_req, m_gnt, m_rvalid, m_err;
  logic [31:0] f_instr, m_addr, m_rdata;
  int          pass_cnt = 0, tot_cnt = 0;
  logic        mon_en = 1'b0, exp_req = 1'b0, exp_ack = 1'b0;
  logic [31:0] mdl_instr = '0;
  logic        mdl_fault = 1'b0;
  logic [32:0] ackq[$];
  logic [31:0] reqq[$];

  always #5 clk = ~clk;

  rv_ibus_bridge #(.IADDR_SPACE_BITS(16)) dut (
    .i_clk(clk), .i_reset(rst), .i_f_addr(f_addr), .i_f_cyc(f_cyc), .i_flush(flush),
    .o_f_ack(f_ack), .o_f_instruction(f_instr), .o_f_fault(f_fault),
    .o_m_req(m_req), .o_m_addr(m_addr), .i_m_gnt(m_gnt), .i_m_rvalid(m_rvalid),
    .i_m_rdata(m_rdata), .i_m_err(m_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  function automatic logic exp_fault(input logic e);
`ifdef RV_IBUS_ERR_EN
    return e;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cyc, input logic [15:0] a, input logic fl, input logic g,
                       input logic rv, input logic [31:0] d, input logic e);
    f_cyc = cyc; f_addr = a; flush = fl; m_gnt = g; m_rvalid = rv; m_rdata = d; m_err = e;
  endtask

  // One fetch: gd wait cycles before grant, rd before rvalid, flush at cycle fc (-1 none),
  // hold cycles with cyc low after the word returns, then endm: 0 ack, 1 address change, 2 flush.
  task automatic txn(input logic [15:0] a, input int gd, input int rd, input int fc, input int hold,
                     input int endm, input logic [15:0] na, input logic [31:0] d, input logic e);
    int  rv = gd + 1 + rd;
    bit  cap = (fc < 0) || (fc == rv);
    drive(1'b1, a, 1'b0, 1'b0, 1'b0, $urandom, 1'b0);
    exp_req = 1'b0; exp_ack = 1'b0;
    reqq.push_back({16'h0, a[15:2], 2'b00});
    step();
    for (int c = 0; c <= rv; c++) begin
      logic cyc = (c < rv) ? 1'($urandom) : (fc == rv) ? 1'($urandom) : (hold == 0);
      drive(cyc, a ^ 16'($urandom_range(0, 3)), c == fc, c == gd,
            (c == rv) || (c <= gd && $urandom_range(0, 3) == 0),
            (c == rv) ? d : $urandom, (c == rv) ? e : 1'($urandom));
      exp_req = c <= gd;
      exp_ack = (c == rv) && fc < 0 && hold == 0;
      if (exp_ack) ackq.push_back({exp_fault(e), d});
      step();
      if (c == rv && cap) begin
        mdl_instr = d;
        mdl_fault = exp_fault(e);
      end
    end
    exp_req = 1'b0;
    if (fc < 0 && hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        drive(1'b0, a, 1'b0, 1'b0, 1'($urandom), $urandom, 1'($urandom));
        exp_ack = 1'b0;
        step();
      end
      if (endm == 0) drive(1'b1, a ^ 16'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0, $urandom, 1'b0);
      else if (endm == 1) drive(1'($urandom), na, 1'b0, 1'b0, 1'b0, $urandom, 1'b0);
      else drive(1'($urandom), a, 1'b1, 1'b0, 1'b0, $urandom, 1'b0);
      exp_ack = endm == 0;
      if (exp_ack) ackq.push_back({mdl_fault, mdl_instr});
      step();
    end
    exp_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 16'($urandom), 1'($urandom), 1'b0, 1'($urandom), $urandom, 1'($urandom));
      exp_req = 1'b0; exp_ack = 1'b0;
      step();
    end
  endtask

  // Monitor: compares the DUT against the expectations the driver has queued.
  initial begin
    logic        pend = 1'b0;
    logic [32:0] pv = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (pend) begin
          chk("ack_data", f_instr, pv[31:0]);
          chk("ack_fault", f_fault, pv[32]);
        end
        pend = 1'b0;
        chk("ack", f_ack, exp_ack);
        if (f_ack) begin
          if (ackq.size() == 0) chk("ack_unexpected", 1, 0);
          else begin
            pv = ackq.pop_front();
            pend = 1'b1;
          end
        end
        chk("m_req", m_req, exp_req);
        if (m_req) begin
          if (reqq.size() == 0) chk("req_unexpected", 1, 0);
          else begin
            chk("m_addr", m_addr, reqq[0]);
            if (m_gnt) void'(reqq.pop_front());
          end
        end
        chk("instr_reg", f_instr, mdl_instr);
        chk("fault_reg", f_fault, mdl_fault);
      end
    end
  end

  initial begin
    rst = 1'b1;
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 1'b1);
    step(); step();
    mon_en = 1'b1;
    rst = 1'b0;
    chk("rst_m_addr", m_addr, 32'h0);
    idle(2);
    txn(16'h0104, 0, 0, -1, 0, 0, 16'h0, 32'h00A00093, 1'b0);
    txn(16'h0108, 0, 0, -1, 0, 0, 16'h0, 32'h00B00113, 1'b0);
    chk("zero_wait_addr_held", m_addr, 32'h108);
    txn(16'h0104, 3, 1, 1, 0, 0, 16'h0, 32'h12345678, 1'b1);
    txn(16'h0104, 0, 0, -1, 4, 0, 16'h0, 32'hCAFEF00D, 1'b0);
    txn(16'h0104, 0, 0, -1, 2, 1, 16'h0200, 32'h0badf00d, 1'b0);
    txn(16'h0200, 1, 2, -1, 0, 0, 16'h0, 32'h00000513, 1'b1);
    txn(16'h0300, 0, 2, 2, 0, 0, 16'h0, 32'h11111111, 1'b0);
    txn(16'h0304, 0, 1, 2, 0, 0, 16'h0, 32'h22222222, 1'b1);
    idle(1);
    drive(1'b1, 16'h0400, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    reqq.push_back(32'h400);
    step();
    drive(1'b1, 16'h0400, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    exp_req = 1'b1;
    step();
    exp_req = 1'b0;
    rst = 1'b1;
    drive(1'b0, 16'h0400, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step();
    rst = 1'b0;
    mdl_instr = '0;
    mdl_fault = 1'b0;
    drive(1'b0, 16'h0400, 1'b0, 1'b0, 1'b1, 32'h99999999, 1'b1);
    step();
    chk("rst_mid_m_addr", m_addr, 32'h0);
    idle(2);
    for (int t = 0; t < 300; t++) begin
      logic [15:0] a = 16'($urandom);
      int gd = $urandom_range(0, 3), rd = $urandom_range(0, 3);
      int fc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, gd + 1 + rd) : -1;
      int hold = $urandom_range(0, 1) ? $urandom_range(1, 3) : 0;
      txn(a, gd, rd, fc, hold, $urandom_range(0, 2), a ^ {14'($urandom_range(1, 16383)), 2'b00},
          $urandom, 1'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(3);
    chk("ackq_drained", ackq.size(), 0);
    chk("reqq_drained", reqq.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule

// File: doc/rv_ibus_bridge.md
RV_IBUS_BRIDGE -- requirements
Module: rv_ibus_bridge

Interface
REQ-001 SHALL have parameter IADDR_SPACE_BITS, default 16, fetch address width.
REQ-002 SHALL have one clock and a synchronous, active-high reset; ports i_clk then i_reset, as listed below.
REQ-003 SHALL have port i_clk  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_f_addr  input  IADDR_SPACE_BITS  fetch address; bits [1:0] ignored.
REQ-006 SHALL have port i_f_cyc  input  1  fetch requests a word.
REQ-007 SHALL have port i_flush  input  1  pipeline flush/redirect.
REQ-008 SHALL have port o_f_ack  output  1  word accepted; data valid next cycle.
REQ-009 SHALL have port o_f_instruction  output  32  fetched word.
REQ-010 SHALL have port o_f_fault  output  1  bus error qualifier for o_f_instruction.
REQ-011 SHALL have memory ports o_m_req out 1, o_m_addr out 32, i_m_gnt in 1, i_m_rvalid in 1, i_m_rdata in 32, i_m_err in 1 (OBI-style, one outstanding).

Function
REQ-012 SHALL implement FSM states IDLE, REQ, WAIT, HOLD, DROP.
REQ-013 IDLE: if i_f_cyc & !i_flush, SHALL latch addr_q = {i_f_addr[IADDR_SPACE_BITS-1:2], 2'b00} and go to REQ.
REQ-014 REQ: o_m_req=1, o_m_addr=addr_q zero-extended to 32; both SHALL stay stable until i_m_gnt.
REQ-015 REQ with i_m_gnt: next state SHALL be DROP if i_flush was seen since latch or is active now, else WAIT; a flush in REQ SHALL NOT drop o_m_req.
REQ-016 i_m_rvalid SHALL be honoured only in WAIT and DROP; ignored in IDLE, REQ, HOLD.
REQ-017 WAIT with i_m_rvalid: SHALL capture i_m_rdata into o_f_instruction register (and i_m_err into fault register).
REQ-018 In that cycle: i_flush -> IDLE, no ack; else i_f_cyc & i_f_addr[..:2]==addr_q[..:2] -> o_f_ack=1 combinationally, -> IDLE; else -> HOLD.
REQ-019 WAIT with i_flush and no i_m_rvalid SHALL go to DROP.
REQ-020 HOLD: i_flush -> IDLE; address mismatch -> IDLE, word discarded; i_f_cyc & match -> o_f_ack=1, -> IDLE; else remain.
REQ-021 DROP: on i_m_rvalid SHALL go to IDLE with o_f_ack=0 and no register update.
REQ-022 o_f_ack SHALL be asserted only in WAIT/HOLD per REQ-018/020, never while i_flush=1.
REQ-023 o_f_instruction/o_f_fault SHALL hold their value until the next capture.
REQ-024 Minimum latency with zero-wait memory (gnt in REQ, rvalid next cycle): ack 2 cycles after IDLE latch; throughput one word per 3 cycles.

Reset
REQ-025 On i_reset: state IDLE, o_m_req=0, o_m_addr=0, o_f_ack=0, o_f_instruction=0, o_f_fault=0.
REQ-026 Reset mid-transaction SHALL abandon it; stray i_m_rvalid after reset SHALL be ignored (REQ-016).

Configuration
REQ-027 Macro RV_IBUS_ERR_EN defined: o_f_fault SHALL be the registered i_m_err captured with the word.
REQ-028 RV_IBUS_ERR_EN undefined: o_f_fault SHALL be constant 0, i_m_err unused, port list unchanged.

Verification
REQ-029 Zero-wait fetch addr 0x0104, cyc=1, rdata 0x00A00093 -> o_m_addr 0x104 in REQ; ack 2 cycles after latch; o_f_instruction=0x00A00093 next cycle.
REQ-030 gnt delayed 3 cycles, flush in 2nd REQ cycle -> o_m_req held until gnt, DROP entered, rvalid gives no ack, instruction register unchanged.
REQ-031 cyc=0 when rvalid arrives (fetch full), raise cyc 4 cycles later, same addr -> HOLD 4 cycles, then single ack, correct data.
REQ-032 In HOLD, i_f_addr changes 0x0104 -> 0x0200 -> return to IDLE, no ack, new request for 0x200.
REQ-033 With RV_IBUS_ERR_EN, rvalid with i_m_err=1 -> o_f_fault=1 alongside data; without the macro o_f_fault=0.
REQ-034 Assert i_reset in WAIT, then rvalid in IDLE -> no ack, all outputs at reset values.
